icache_direct_mapped: RTL and testbench
=======================================

Name: icache_direct_mapped

Overview:
- Direct-mapped, read-only instruction cache between the PC/IF stage and instruction port A of the external memory.
- Hits return the instruction in the same cycle.
- Misses raise icache_stall, refill one line word-by-word over a request/valid handshake, install the line, then return the hit.
- Drives the IF stage's IStall input and the PC's icache_stall input; supports whole-cache invalidate.

Parameters:
- LINE_WORDS, 4, 32-bit words per line; power of two, 2..16.
- NUM_LINES, 64, number of lines; power of two, 4..256.
- NOP_INST, 32'h00000013, value driven on inst_out whenever inst_valid=0.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- pc_in  input  32  fetch byte address; bits [1:0] ignored.
- fetch_req  input  1  IF requests the instruction at pc_in this cycle.
- invalidate  input  1  one-cycle pulse; clears all valid bits.
- inst_out  output  32  instruction for pc_in when inst_valid=1; NOP_INST otherwise.
- inst_valid  output  1  fetch_req & hit & state==IDLE; combinational.
- icache_stall  output  1  fetch_req & ~inst_valid; combinational.
- mem_req  output  1  registered; word read request to memory port A.
- mem_addr  output  32  registered; word-aligned refill address.
- mem_rdata  input  32  refill data; valid only when mem_rvalid=1.
- mem_rvalid  input  1  one-cycle pulse; accepts the current request and returns its data.
- hit_count  output  32  saturating count of cycles with inst_valid=1.
- miss_count  output  32  saturating count of refills started.

Behaviour:
- Address split:
  - OFF = log2(LINE_WORDS)+2; IDX = log2(NUM_LINES).
  - index = pc_in[OFF+IDX-1:OFF]; word = pc_in[OFF-1:2]; tag = pc_in[31:OFF+IDX].
  - Defaults: tag is 22 bits, index 6, word 2.
- Storage:
  - valid bits and tags in flops.
  - Data array readable combinationally (distributed RAM acceptable).
  - hit = valid[index] & (tag_array[index]==tag).
- Reset (rst=0 at edge):
  - state=IDLE; all valid=0; mem_req=0; mem_addr=0; word counter=0; invalidate_pending=0; hit_count=miss_count=0.
  - inst_out=NOP_INST and inst_valid=0 follow combinationally.
  - Reset during REFILL abandons the refill: the line is not installed and mem_req is low after the edge.
- FSM states: IDLE, REFILL.
  - IDLE:
    - If fetch_req & ~hit: latch refill_base = {pc_in[31:OFF], OFF'b0}, count=0, mem_req=1, mem_addr=refill_base, miss_count+1, go to REFILL.
    - invalidate in IDLE clears all valid bits at the edge. If it coincides with a miss, the miss still starts.
  - REFILL:
    - mem_req holds high with stable mem_addr until mem_rvalid.
    - On mem_rvalid: write mem_rdata to data[line][count]; count+1; mem_addr+4.
    - On the last word (count==LINE_WORDS-1) with mem_rvalid:
      - mem_req=0, tag written, state=IDLE.
      - valid[line]=1 unless invalidate_pending, which is then cleared.
    - invalidate during REFILL sets invalidate_pending and clears all valid bits at that edge.
    - fetch_req, pc_in and branch redirects are ignored during REFILL. The refill always completes.
- Outputs:
  - icache_stall is high for every REFILL cycle in which fetch_req=1.
  - The first post-refill hit is in the cycle after the last mem_rvalid.
  - Miss penalty = sum of per-word memory latencies + 1 cycle.
- mem_rvalid while mem_req=0 is ignored.
- fetch_req=0: no lookup side effects, icache_stall=0, inst_valid=0.
- Counters saturate at 32'hFFFFFFFF; no wrap.

Test Plan:
- Reset then fetch pc=0x0000_0040, memory returns 0xA0..0xA3 with rvalid 2 cycles after each request:
  - mem_addr sequence 0x40, 0x44, 0x48, 0x4C.
  - Stall lasts 9 cycles.
  - inst_out=0xA0 then hits.
  - miss_count=1.
- After that fill, fetch 0x44, 0x48, 0x4C back-to-back → inst_valid=1 each cycle, inst_out 0xA1, 0xA2, 0xA3, no mem_req, hit_count=4.
- Conflict case: fetch 0x0000_0440 (same index 4, different tag) → refill, then 0x40 misses again; miss_count=3.
- invalidate pulse in mid-REFILL:
  - the line completes but stays invalid;
  - the next fetch of the same pc misses;
  - mem_req rises the cycle after return to IDLE.
- rst=0 asserted during the 2nd refill word:
  - mem_req=0 and state IDLE after the edge; counters=0;
  - a prior fetch of 0x40 misses.
- pc_in with bits[1:0]=2'b11 returns the same word as the aligned address. Spurious mem_rvalid in IDLE causes no array write.

Source files
------------

// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache. Hits return in the same cycle;
// misses refill one line word-by-word over a req/rvalid handshake to memory.
module icache_direct_mapped #(
    parameter int          LINE_WORDS = 4,
    parameter int          NUM_LINES  = 64,
    parameter logic [31:0] NOP_INST   = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic        fetch_req,
    input  logic        invalidate,
    output logic [31:0] inst_out,
    output logic        inst_valid,
    output logic        icache_stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);
    localparam int WB   = $clog2(LINE_WORDS);
    localparam int OFF  = WB + 2;
    localparam int IDX  = $clog2(NUM_LINES);
    localparam int TAGW = 32 - OFF - IDX;

    typedef enum logic {IDLE, REFILL} state_t;

    state_t                state, state_nxt;
    logic [NUM_LINES-1:0]  valid;
    logic [TAGW-1:0]       tag_array  [NUM_LINES];
    logic [31:0]           data_array [NUM_LINES][LINE_WORDS];
    logic [IDX-1:0]        line;
    logic [TAGW-1:0]       refill_tag;
    logic [WB-1:0]         count;
    logic                  invalidate_pending;

    logic [IDX-1:0]        index;
    logic [WB-1:0]         word;
    logic [TAGW-1:0]       tag;
    logic                  hit, miss, word_done, last_word;
    logic                  unused_pc_bits;

    assign index          = pc_in[OFF+IDX-1:OFF];
    assign word           = pc_in[OFF-1:2];
    assign tag            = pc_in[31:OFF+IDX];
    assign unused_pc_bits = ^pc_in[1:0];

    assign hit          = valid[index] && (tag_array[index] == tag);
    assign inst_valid   = fetch_req && hit && (state == IDLE);
    assign inst_out     = inst_valid ? data_array[index][word] : NOP_INST;
    assign icache_stall = fetch_req && !inst_valid;
    assign miss         = fetch_req && !hit && (state == IDLE);
    assign word_done    = (state == REFILL) && mem_rvalid;
    // LINE_WORDS is a power of two, so the final word has an all-ones counter
    assign last_word    = word_done && (&count);

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (miss)      state_nxt = REFILL;
            REFILL:  if (last_word) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid              <= '0;
            mem_req            <= 1'b0;
            mem_addr           <= '0;
            count              <= '0;
            invalidate_pending <= 1'b0;
            line               <= '0;
            refill_tag         <= '0;
            hit_count          <= '0;
            miss_count         <= '0;
        end else begin
            if (inst_valid && hit_count != 32'hFFFF_FFFF)
                hit_count <= hit_count + 32'd1;
            case (state)
                IDLE: begin
                    if (invalidate) valid <= '0;
                    if (miss) begin
                        line       <= index;
                        refill_tag <= tag;
                        count      <= '0;
                        mem_req    <= 1'b1;
                        mem_addr   <= {pc_in[31:OFF], {OFF{1'b0}}};
                        if (miss_count != 32'hFFFF_FFFF)
                            miss_count <= miss_count + 32'd1;
                    end
                end
                REFILL: begin
                    if (invalidate) begin
                        valid              <= '0;
                        invalidate_pending <= 1'b1;
                    end
                    if (word_done) begin
                        count    <= count + 1'b1;
                        mem_addr <= mem_addr + 32'd4;
                    end
                    // an invalidate landing on the last beat also keeps the line invalid
                    if (last_word) begin
                        mem_req            <= 1'b0;
                        invalidate_pending <= 1'b0;
                        if (!invalidate_pending && !invalidate)
                            valid[line] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Arrays are not reset; a refill cut short by reset never sets valid.
    always_ff @(posedge clk) begin
        if (rst && word_done) begin
            data_array[line][count] <= mem_rdata;
            if (&count) tag_array[line] <= refill_tag;
        end
    end
endmodule

// File: tb/tb_icache_direct_mapped.sv
// Directed bench for icache_direct_mapped with a fixed-latency memory model
// (rvalid on the second cycle of each request).
module tb_icache_direct_mapped;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_in = '0;
    logic        fetch_req = 1'b0;
    logic        invalidate = 1'b0;
    logic [31:0] inst_out;
    logic        inst_valid, icache_stall, mem_req;
    logic [31:0] mem_addr, mem_rdata;
    logic        mem_rvalid;
    logic [31:0] hit_count, miss_count;

    logic        m_rvalid = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        spur = 1'b0;
    int          wait_cnt = 0;
    logic [31:0] addr_q[$];

    int checks = 0;
    int errors = 0;

    assign mem_rvalid = m_rvalid | spur;
    assign mem_rdata  = spur ? 32'hDEAD_BEEF : m_rdata;

    icache_direct_mapped #(.LINE_WORDS(4), .NUM_LINES(64), .NOP_INST(32'h0000_0013)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .fetch_req(fetch_req), .invalidate(invalidate),
        .inst_out(inst_out), .inst_valid(inst_valid), .icache_stall(icache_stall),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a >= 32'h40 && a <= 32'h4C) return 32'hA0 + ((a - 32'h40) >> 2);
        return a ^ 32'hC0DE_0000;
    endfunction

    always @(negedge clk) begin
        if (mem_req) begin
            if (wait_cnt == 1) begin
                m_rvalid = 1'b1;
                m_rdata  = mem_word(mem_addr);
                addr_q.push_back(mem_addr);
                wait_cnt = 0;
            end else begin
                m_rvalid = 1'b0;
                wait_cnt = wait_cnt + 1;
            end
        end else begin
            m_rvalid = 1'b0;
            wait_cnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; holds fetch_req until the hit, returns at the next negedge.
    task automatic do_fetch(input logic [31:0] pc, input int inv_at,
                            output int stalls, output logic [31:0] inst);
        stalls    = 0;
        pc_in     = pc;
        fetch_req = 1'b1;
        #1;
        while (!inst_valid && stalls < 200) begin
            stalls++;
            @(negedge clk);
            invalidate = (stalls == inv_at);
            #1;
        end
        if (!inst_valid) chk("fetch_timeout", 32'(stalls), 32'd0);
        inst = inst_out;
        @(negedge clk);
        fetch_req  = 1'b0;
        invalidate = 1'b0;
    endtask

    int          st;
    logic [31:0] ins;

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_inst_out", inst_out, 32'h13);
        chk("rst_inst_valid", 32'(inst_valid), 0);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_hits", hit_count, 0);
        chk("rst_misses", miss_count, 0);
        chk("rst_stall_idle", 32'(icache_stall), 0);
        @(negedge clk);
        rst = 1'b1;

        addr_q.delete();
        do_fetch(32'h40, -1, st, ins);
        chk("fill_stalls", 32'(st), 9);
        chk("fill_inst", ins, 32'hA0);
        chk("fill_misses", miss_count, 1);
        chk("fill_nbeats", 32'(addr_q.size()), 4);
        for (int i = 0; i < 4 && i < addr_q.size(); i++)
            chk("fill_addr", addr_q[i], 32'h40 + 32'(4 * i));

        for (int i = 1; i < 4; i++) begin
            do_fetch(32'h40 + 32'(4 * i), -1, st, ins);
            chk("hit_stalls", 32'(st), 0);
            chk("hit_inst", ins, 32'hA0 + 32'(i));
            chk("hit_no_req", 32'(mem_req), 0);
        end
        chk("hit_count4", hit_count, 4);

        do_fetch(32'h43, -1, st, ins);
        chk("unaligned_stalls", 32'(st), 0);
        chk("unaligned_inst", ins, 32'hA0);

        @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        do_fetch(32'h40, -1, st, ins);
        chk("spurious_stalls", 32'(st), 0);
        chk("spurious_inst", ins, 32'hA0);

        do_fetch(32'h440, -1, st, ins);
        chk("conflict_stalls", 32'(st), 9);
        chk("conflict_inst", ins, 32'hC0DE_0440);
        do_fetch(32'h40, -1, st, ins);
        chk("evicted_stalls", 32'(st), 9);
        chk("evicted_inst", ins, 32'hA0);
        chk("miss_count3", miss_count, 3);
        chk("hit_count8", hit_count, 8);

        // invalidate mid-refill: line lands invalid, held fetch re-misses at once
        addr_q.delete();
        do_fetch(32'h80, 3, st, ins);
        chk("inv_stalls", 32'(st), 18);
        chk("inv_inst", ins, 32'hC0DE_0080);
        chk("inv_nbeats", 32'(addr_q.size()), 8);
        if (addr_q.size() >= 5) chk("inv_refetch_addr", addr_q[4], 32'h80);
        chk("inv_misses", miss_count, 5);
        do_fetch(32'h40, -1, st, ins);
        chk("inv_all_stalls", 32'(st), 9);
        chk("pre_rst_hits", hit_count, 10);
        chk("pre_rst_misses", miss_count, 6);

        // reset while the second refill word is outstanding
        addr_q.delete();
        pc_in     = 32'hC0;
        fetch_req = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_mid_req", 32'(mem_req), 0);
        chk("rst_mid_hits", hit_count, 0);
        chk("rst_mid_misses", miss_count, 0);
        chk("rst_mid_valid", 32'(inst_valid), 0);
        chk("rst_mid_stall", 32'(icache_stall), 1);
        chk("rst_mid_beats", 32'(addr_q.size()), 1);
        rst       = 1'b1;
        fetch_req = 1'b0;
        @(negedge clk);
        do_fetch(32'h40, -1, st, ins);
        chk("post_rst_stalls", 32'(st), 9);
        chk("post_rst_inst", ins, 32'hA0);
        chk("post_rst_misses", miss_count, 1);
        do_fetch(32'hC0, -1, st, ins);
        chk("abandoned_stalls", 32'(st), 9);
        chk("abandoned_inst", ins, 32'hC0DE_00C0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
